mem_access_unit: RTL and testbench

Multicycle load/store front-end between the OTTER control unit and the `memory` block. It accepts one load or store request per handshake and registers it. Store data is steered onto the correct byte lanes, and load data is extracted and zero- or sign-extended from the word that `memory` returns. Faults come from the `memory` range/alignment check.

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
//==============================================================================
// Module      : mem_access_unit
// Description : Multicycle load/store front-end between the OTTER control unit
//               and the memory block. Captures one request per handshake,
//               steers store data onto byte lanes, extracts and extends load
//               data, and reports range/alignment faults.
//               Optional feature macro: MAU_FAULT_EN (fault detection).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_unit #(
   parameter int ADDR_WIDTH = 13,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [BUS_WIDTH-1:0] req_addr,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   input  logic [1:0]           req_size,
   input  logic                 req_sign,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [BUS_WIDTH-1:0] resp_rdata,
   output logic                 resp_fault,
   output logic                 mem_we,
   output logic [BUS_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0] mem_data,
   output logic [1:0]           mem_size,
   output logic                 mem_sign,
   input  logic [BUS_WIDTH-1:0] mem_out,
   input  logic                 mem_error
);

   // The word RAM cannot be addressed wider than the bus that carries its address
   generate
      if (ADDR_WIDTH > BUS_WIDTH) begin : g_check_addr_width
         $error("mem_access_unit: ADDR_WIDTH must not exceed BUS_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t               state;
   logic                 cap_we;
   logic [BUS_WIDTH-1:0] cap_addr;
   logic [BUS_WIDTH-1:0] cap_wdata;
   logic [1:0]           cap_size;
   logic                 cap_sign;

   logic                 fault;
   logic [1:0]           eff_size;
   logic [4:0]           lane_shift;
   logic [BUS_WIDTH-1:0] shifted;
   logic [BUS_WIDTH-1:0] load_data;

`ifdef MAU_FAULT_EN
   // Fault is the memory's range/alignment check or the reserved size code
   assign fault    = mem_error || (cap_size == 2'b11);
   assign eff_size = cap_size;
`else
   // Faults disabled: memory error is ignored and the reserved size acts as word
   logic unused_mem_error;
   assign unused_mem_error = mem_error;
   assign fault    = 1'b0;
   assign eff_size = (cap_size == 2'b11) ? 2'b10 : cap_size;
`endif

   // Byte-lane offset of the captured address, in bits
   assign lane_shift = {cap_addr[1:0], 3'b000};

   // Memory side is always driven from the capture register
   assign mem_addr = cap_addr;
   assign mem_size = eff_size;
   assign mem_sign = cap_sign;
   assign mem_data = cap_wdata << lane_shift;

   // Write strobe exists only in ISSUE for a non-faulting store
   assign mem_we    = (state == ISSUE) && cap_we && !fault;
   // Ready only in IDLE, and held low while reset is applied
   assign req_ready = (state == IDLE) && !rst;

   // Extract the addressed field from the returned word and extend it
   always_comb begin
      shifted = mem_out >> lane_shift;
      case (eff_size)
         2'b00:   load_data = {{(BUS_WIDTH-8){shifted[7] & ~cap_sign}}, shifted[7:0]};
         2'b01:   load_data = {{(BUS_WIDTH-16){shifted[15] & ~cap_sign}}, shifted[15:0]};
         default: load_data = mem_out;
      endcase
   end

   // Request capture, sequencing and registered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cap_we     <= 1'b0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         cap_size   <= 2'b00;
         cap_sign   <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_we     <= req_we;
                  cap_addr   <= req_addr;
                  cap_wdata  <= req_wdata;
                  cap_size   <= req_size;
                  cap_sign   <= req_sign;
                  resp_rdata <= '0;
                  resp_fault <= 1'b0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (fault) begin
                  resp_fault <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (cap_we) begin
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  state <= READ;
               end
            end
            READ: begin
               resp_rdata <= load_data;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a small
//               byte-lane memory model (range limit 0x2000 bytes).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_sign;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [1:0]  mem_size;
   logic        mem_sign;
   logic [31:0] mem_out;
   logic        mem_error;

   int n_checks;
   int n_fail;

   logic [31:0] ram [0:2047];

   mem_access_unit #(.ADDR_WIDTH(13), .BUS_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_size   (req_size),
      .req_sign   (req_sign),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_size   (mem_size),
      .mem_sign   (mem_sign),
      .mem_out    (mem_out),
      .mem_error  (mem_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: range and alignment error, byte-lane writes, registered read
   assign mem_error = (mem_addr >= 32'h2000) ||
                      (mem_size == 2'b01 && mem_addr[0]) ||
                      (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

   always @(posedge clk) begin
      if (mem_we) begin
         case (mem_size)
            2'b00:   ram[mem_addr[12:2]][8*mem_addr[1:0] +: 8] <= mem_data[8*mem_addr[1:0] +: 8];
            2'b01:   ram[mem_addr[12:2]][16*mem_addr[1] +: 16] <= mem_data[16*mem_addr[1] +: 16];
            default: ram[mem_addr[12:2]] <= mem_data;
         endcase
      end
      mem_out <= ram[mem_addr[12:2]];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request; optionally hold resp_ready low for 'hold' cycles in RESP
   task automatic access(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic sign, input int hold,
                         output logic [31:0] rdata, output logic fault,
                         output int wecnt, output int lat);
      logic [31:0] snap;
      @(negedge clk);
      check_val({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      resp_ready = (hold == 0);
      req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_sign = sign;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      // Scramble inputs after the accept edge; they must have no effect
      req_valid = 1'b0;
      req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_size = ~size; req_sign = ~sign;
      wecnt = 0;
      lat   = 0;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         if (mem_we) wecnt++;
         lat++;
      end
      check_val({tag, "_timeout"}, {31'b0, (lat >= 20)}, 32'd0);
      rdata = resp_rdata;
      fault = resp_fault;
      snap  = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
         check_val({tag, "_hold_rdata"}, resp_rdata, snap);
         check_val({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val({tag, "_back_idle"}, {30'b0, req_ready, resp_valid}, 32'd2);
   endtask

   logic [31:0] rd;
   logic        flt;
   int          wc;
   int          lt;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
      ram[32'h100 >> 2] = 32'h11223344;
      ram[32'h200 >> 2] = 32'h8001F0FF;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'b00; req_sign = 1'b0; resp_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check_val("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check_val("rst_rdata", resp_rdata, 32'd0);
      rst = 1'b0;
      #1;
      check_val("rel_req_ready", {31'b0, req_ready}, 32'd1);

      // Store byte to 0x103, then read the word back
      access("st_byte", 1'b1, 32'h0103, 32'h000000AB, 2'b00, 1'b0, 0, rd, flt, wc, lt);
      check_val("st_byte_we_cnt", wc, 32'd1);
      check_val("st_byte_lat", lt, 32'd2);
      check_val("st_byte_fault", {31'b0, flt}, 32'd0);
      check_val("st_byte_rdata", rd, 32'd0);
      access("ld_word", 1'b0, 32'h0100, 32'h0, 2'b10, 1'b0, 0, rd, flt, wc, lt);
      check_val("ld_word_data", rd, 32'hAB223344);
      check_val("ld_word_lat", lt, 32'd3);
      check_val("ld_word_we_cnt", wc, 32'd0);

      // Loads with extension from 0x8001F0FF at 0x200
      access("ld_b_s", 1'b0, 32'h0200, 32'h0, 2'b00, 1'b0, 0, rd, flt, wc, lt);
      check_val("ld_b_s_data", rd, 32'hFFFFFFFF);
      access("ld_b_z", 1'b0, 32'h0201, 32'h0, 2'b00, 1'b1, 0, rd, flt, wc, lt);
      check_val("ld_b_z_data", rd, 32'h000000F0);
      access("ld_h_s", 1'b0, 32'h0202, 32'h0, 2'b01, 1'b0, 0, rd, flt, wc, lt);
      check_val("ld_h_s_data", rd, 32'hFFFF8001);
      access("ld_h_z", 1'b0, 32'h0200, 32'h0, 2'b01, 1'b1, 0, rd, flt, wc, lt);
      check_val("ld_h_z_data", rd, 32'h0000F0FF);
      access("ld_b3_s", 1'b0, 32'h0203, 32'h0, 2'b00, 1'b0, 0, rd, flt, wc, lt);
      check_val("ld_b3_s_data", rd, 32'hFFFFFF80);

      // Back-pressure on a load
      access("bp", 1'b0, 32'h0201, 32'h0, 2'b00, 1'b1, 5, rd, flt, wc, lt);
      check_val("bp_data", rd, 32'h000000F0);

      // Misaligned word store, out-of-range load, reserved size
      access("mis_st", 1'b1, 32'h0102, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, flt, wc, lt);
      check_val("mis_st_rdata", rd, 32'd0);
      check_val("mis_st_lat", lt, 32'd2);
`ifdef MAU_FAULT_EN
      check_val("mis_st_fault", {31'b0, flt}, 32'd1);
      check_val("mis_st_we_cnt", wc, 32'd0);
      check_val("mis_st_mem", ram[32'h100 >> 2], 32'hAB223344);
`else
      check_val("mis_st_fault", {31'b0, flt}, 32'd0);
      check_val("mis_st_we_cnt", wc, 32'd1);
`endif
      access("oor_ld", 1'b0, 32'h2000, 32'h0, 2'b10, 1'b0, 0, rd, flt, wc, lt);
`ifdef MAU_FAULT_EN
      check_val("oor_ld_fault", {31'b0, flt}, 32'd1);
      check_val("oor_ld_rdata", rd, 32'd0);
      check_val("oor_ld_lat", lt, 32'd2);
`else
      check_val("oor_ld_fault", {31'b0, flt}, 32'd0);
      check_val("oor_ld_lat", lt, 32'd3);
`endif
      access("sz11", 1'b0, 32'h0200, 32'h0, 2'b11, 1'b0, 0, rd, flt, wc, lt);
`ifdef MAU_FAULT_EN
      check_val("sz11_fault", {31'b0, flt}, 32'd1);
      check_val("sz11_rdata", rd, 32'd0);
`else
      check_val("sz11_fault", {31'b0, flt}, 32'd0);
      check_val("sz11_rdata", rd, 32'h8001F0FF);
`endif

      // Asynchronous reset during ISSUE of a store
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h0300; req_wdata = 32'h00000055;
      req_size = 2'b00; req_sign = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_val("rst_mid_we_before", {31'b0, mem_we}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check_val("rst_mid_we", {31'b0, mem_we}, 32'd0);
      check_val("rst_mid_ready", {31'b0, req_ready}, 32'd0);
      check_val("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
      check_val("rst_mid_rdata", resp_rdata, 32'd0);
      check_val("rst_mid_fault", {31'b0, resp_fault}, 32'd0);
      check_val("rst_mid_addr", mem_addr, 32'd0);
      check_val("rst_mid_data", mem_data, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_mid_mem", ram[32'h300 >> 2], 32'd0);
      check_val("rst_mid_rel_ready", {31'b0, req_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
